// File: rtl/serial_full_adder_if.sv
// Request/result bundle for serial_full_adder.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_full_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_full_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_full_adder_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_c, carry_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // The single full-adder cell.
  assign s_c     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign carry_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath control; sum/cout only update on completion.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SERIAL_ADD_OVF_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        c_d    = carry_c;
        cnt_d  = cnt_q + CW'(1);
        psum_d = {s_c, psum_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {s_c, psum_q[WIDTH-1:1]};
          cout_d  = carry_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (s_c != a_msb_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed, table-driven bench for serial_full_adder (WIDTH=8).
// Overflow expectations are checked only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_full_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_full_adder_if #(.WIDTH(W)) bus ();

  serial_full_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("done_after_accept", 32'(bus.done), 32'd0);
  endtask

  // Counts edges after acceptance until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) break;
      chk("busy_during_shift", 32'(bus.busy), 32'd1);
    end
    chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] es, input logic ec,
                              input logic eo);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
  endtask

  initial begin
    vec_t vecs[8];
    int   cyc;
    total = 0;
    bad   = 0;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'hFC, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{8'h03, 8'hFA, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    clk       = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_result("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of independent operations with a gap cycle after each.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(cyc);
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(W));
      check_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check_result($sformatf("vec%0d_hold", i), vecs[i].exp_sum, vecs[i].exp_cout,
                   vecs[i].exp_ovf);
    end

    // Start during SHIFT must be ignored.
    start_op(8'h3C, 8'h05, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_no_partial_sum", 32'(bus.sum), 32'h30);
    wait_done(cyc);
    chk("ign_latency", 32'(cyc), 32'(W - 4));
    check_result("ign", 8'h41, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ign_done_pulse", 32'(bus.done), 32'd0);

    // Back-to-back: start held in the DONE cycle.
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(cyc);
    check_result("b2b_first", 8'h03, 1'b0, 1'b0);
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(cyc);
    chk("b2b_second_latency", 32'(cyc + 1), 32'(W + 1));
    check_result("b2b_second", 8'h30, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-SHIFT after three bits aborts the operation.
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    check_result("abort", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (W + 4) begin
        @(posedge clk); #1;
        if (bus.done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    check_result("abort_hold", 8'h00, 1'b0, 1'b0);
    start_op(8'h3C, 8'h05, 1'b0);
    wait_done(cyc);
    chk("post_abort_latency", 32'(cyc), 32'(W));
    check_result("post_abort", 8'h41, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
